// File: rtl/sd_wb_master_arb_pkg.sv
// Shared definitions for the SD data-path Wishbone master arbiter:
// FSM state encoding, default watchdog sizing and round-robin helpers.
package sd_wb_master_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BUSY  = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_e;

  localparam int TMO_CYC_DEF = 255;
  localparam int TMO_W_DEF   = 8;

  // Port index to grant: a lone requester wins, a tie goes to the port not served last.
  function automatic logic arb_pick(input logic req0, input logic req1, input logic last);
    logic pick;
    if (req0 && req1) begin
      pick = ~last;
    end else if (req1) begin
      pick = 1'b1;
    end else begin
      pick = 1'b0;
    end
    return pick;
  endfunction

  function automatic logic [1:0] arb_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sd_wb_master_arb_watchdog.sv
// Ack watchdog: counts stalled strobe cycles, saturates instead of wrapping,
// and flags when the count has reached the timeout limit.
module sd_wb_master_arb_watchdog #(
  parameter int TMO_CYC = 255,
  parameter int TMO_W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_fire
);

  localparam logic [TMO_W-1:0] LP_LIMIT = TMO_W'(TMO_CYC);
  localparam logic [TMO_W-1:0] LP_MAX   = {TMO_W{1'b1}};
  localparam logic [TMO_W-1:0] LP_ONE   = TMO_W'(1'b1);

  logic [TMO_W-1:0] r_cnt;

  // Stall counter: clear wins over increment, and it holds at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {TMO_W{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {TMO_W{1'b0}};
    end else if (i_inc && (r_cnt != LP_MAX)) begin
      r_cnt <= r_cnt + LP_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_fire = (r_cnt == LP_LIMIT);

endmodule

// File: rtl/sd_wb_master_arb.sv
// Two-port Wishbone master arbiter: round-robin grant held for a whole bus cycle,
// with an ack watchdog that terminates a stalled slave access with err.
module sd_wb_master_arb
  import sd_wb_master_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TMO_CYC = TMO_CYC_DEF,
  parameter int TMO_W   = TMO_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic [2:0]      m0_cti_i,
  input  logic [1:0]      m0_bte_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic [2:0]      m1_cti_i,
  input  logic [1:0]      m1_bte_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic [2:0]      wb_cti_o,
  output logic [1:0]      wb_bte_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  input  logic            wb_err_i,
  output logic            tmo_o,
  input  logic            tmo_clr_i,
  output logic [1:0]      gnt_o
);

  arb_state_e r_state;
  logic [1:0] r_gnt;
  logic       r_last;
  logic       r_tmo;

  logic w_sel;
  logic w_owned;
  logic w_live;
  logic w_gcyc;
  logic w_gstb;
  logic w_pick;
  logic w_wd_clr;
  logic w_wd_inc;
  logic w_wd_limit;
  logic w_fire;

  assign w_sel   = r_gnt[1];
  assign w_owned = (r_state != ARB_IDLE);
  assign w_live  = (r_state == ARB_BUSY);
  assign w_gcyc  = w_sel ? m1_cyc_i : m0_cyc_i;
  assign w_gstb  = w_sel ? m1_stb_i : m0_stb_i;
  assign w_pick  = arb_pick(m0_cyc_i, m1_cyc_i, r_last);

  // A response or an idle strobe restarts the stall count; leaving BUSY resets it too.
  assign w_wd_clr = ~w_live | ~w_gstb | wb_ack_i | wb_err_i;
  assign w_wd_inc = w_live & w_gstb;
  assign w_fire   = w_wd_limit & w_live & w_gcyc & w_gstb & ~wb_ack_i & ~wb_err_i;

  sd_wb_master_arb_watchdog #(
    .TMO_CYC (TMO_CYC),
    .TMO_W   (TMO_W)
  ) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_wd_clr),
    .i_inc  (w_wd_inc),
    .o_fire (w_wd_limit)
  );

  // Grant FSM plus sticky timeout flag; a watchdog fire beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
      r_gnt   <= 2'b00;
      r_last  <= 1'b1;
      r_tmo   <= 1'b0;
    end else begin
      if (w_fire) begin
        r_tmo <= 1'b1;
      end else if (tmo_clr_i) begin
        r_tmo <= 1'b0;
      end else begin
        r_tmo <= r_tmo;
      end
      case (r_state)
        ARB_IDLE: begin
          if (m0_cyc_i || m1_cyc_i) begin
            r_state <= ARB_BUSY;
            r_gnt   <= arb_onehot(w_pick);
            r_last  <= w_pick;
          end else begin
            r_state <= ARB_IDLE;
            r_gnt   <= 2'b00;
          end
        end
        ARB_BUSY: begin
          if (!w_gcyc) begin
            r_state <= ARB_IDLE;
            r_gnt   <= 2'b00;
          end else if (w_fire) begin
            r_state <= ARB_DRAIN;
          end else begin
            r_state <= ARB_BUSY;
          end
        end
        ARB_DRAIN: begin
          if (!w_gcyc) begin
            r_state <= ARB_IDLE;
            r_gnt   <= 2'b00;
          end else begin
            r_state <= ARB_DRAIN;
          end
        end
        default: begin
          r_state <= ARB_IDLE;
          r_gnt   <= 2'b00;
        end
      endcase
    end
  end

  // Bus side follows the owner combinationally; DRAIN keeps cyc/stb low so the slave is released.
  always_comb begin
    wb_cyc_o = 1'b0;
    wb_stb_o = 1'b0;
    wb_we_o  = 1'b0;
    wb_adr_o = {AW{1'b0}};
    wb_dat_o = {DW{1'b0}};
    wb_sel_o = {(DW/8){1'b0}};
    wb_cti_o = 3'b000;
    wb_bte_o = 2'b00;
    if (w_owned) begin
      wb_cyc_o = w_live & w_gcyc;
      wb_stb_o = w_live & w_gstb;
      wb_we_o  = w_sel ? m1_we_i  : m0_we_i;
      wb_adr_o = w_sel ? m1_adr_i : m0_adr_i;
      wb_dat_o = w_sel ? m1_dat_i : m0_dat_i;
      wb_sel_o = w_sel ? m1_sel_i : m0_sel_i;
      wb_cti_o = w_sel ? m1_cti_i : m0_cti_i;
      wb_bte_o = w_sel ? m1_bte_i : m0_bte_i;
    end else begin
      wb_cyc_o = 1'b0;
      wb_stb_o = 1'b0;
    end
  end

  assign m0_dat_o = wb_dat_i;
  assign m1_dat_o = wb_dat_i;
  assign m0_ack_o = w_live & wb_ack_i & r_gnt[0];
  assign m1_ack_o = w_live & wb_ack_i & r_gnt[1];
  assign m0_err_o = w_live & (wb_err_i | w_fire) & r_gnt[0];
  assign m1_err_o = w_live & (wb_err_i | w_fire) & r_gnt[1];
  assign tmo_o    = r_tmo;
  assign gnt_o    = r_gnt;

endmodule

// File: tb/tb_sd_wb_master_arb.sv
// Directed bench for sd_wb_master_arb: a per-cycle reference model of the arbiter rules
// plus hand-computed literal expectations for each scenario.
module tb_sd_wb_master_arb;

  localparam int TB_TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_cyc = 1'b0, m0_stb = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_adr = 32'h0, m0_dat = 32'h0;
  logic [3:0]  m0_sel = 4'h0;
  logic [2:0]  m0_cti = 3'b000;
  logic [1:0]  m0_bte = 2'b00;
  logic        m1_cyc = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_adr = 32'h0, m1_dat = 32'h0;
  logic [3:0]  m1_sel = 4'h0;
  logic [2:0]  m1_cti = 3'b000;
  logic [1:0]  m1_bte = 2'b00;
  logic [31:0] wb_dat = 32'h0;
  logic        wb_ack = 1'b0, wb_err = 1'b0, tmo_clr = 1'b0;

  logic [31:0] m0_dat_o, m1_dat_o, wb_adr_o, wb_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, tmo_o;
  logic [3:0]  wb_sel_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o, gnt_o;

  sd_wb_master_arb #(.AW(32), .DW(32), .TMO_CYC(TB_TMO), .TMO_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_cti_i(m0_cti), .m0_bte_i(m0_bte),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_cti_i(m1_cti), .m1_bte_i(m1_bte),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_dat_i(wb_dat), .wb_ack_i(wb_ack), .wb_err_i(wb_err),
    .tmo_o(tmo_o), .tmo_clr_i(tmo_clr), .gnt_o(gnt_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner of the bus (-1 none), whether it was cut off by the watchdog,
  // who was served last, consecutive unanswered strobe cycles, sticky timeout flag.
  int owner = -1;
  bit dead = 1'b0;
  int last = 1;
  int stall = 0;
  bit mtmo = 1'b0;
  int n_ack0 = 0, n_ack1 = 0, n_err0 = 0;

  always @(negedge clk) begin
    logic ocyc, ostb, live, rsp, wd;
    logic [1:0] e_gnt;
    if (m0_ack_o === 1'b1) n_ack0++;
    if (m1_ack_o === 1'b1) n_ack1++;
    if (m0_err_o === 1'b1) n_err0++;
    if (!rst_n) begin
      owner = -1; dead = 1'b0; last = 1; stall = 0; mtmo = 1'b0;
      chk("rst_gnt", gnt_o, 0);
      chk("rst_cyc", wb_cyc_o, 0);
      chk("rst_stb", wb_stb_o, 0);
      chk("rst_adr", wb_adr_o, 0);
      chk("rst_resp", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 0);
      chk("rst_tmo", tmo_o, 0);
    end else begin
      ocyc = (owner == 0) ? m0_cyc : (owner == 1) ? m1_cyc : 1'b0;
      ostb = (owner == 0) ? m0_stb : (owner == 1) ? m1_stb : 1'b0;
      live = (owner >= 0) && !dead;
      rsp  = wb_ack || wb_err;
      wd   = live && ocyc && ostb && !rsp && (stall == TB_TMO);
      e_gnt = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
      chk("m_gnt", gnt_o, e_gnt);
      chk("m_cyc", wb_cyc_o, live && ocyc);
      chk("m_stb", wb_stb_o, live && ostb);
      chk("m_adr", wb_adr_o, (owner == 0) ? m0_adr : (owner == 1) ? m1_adr : 32'h0);
      chk("m_wdat", wb_dat_o, (owner == 0) ? m0_dat : (owner == 1) ? m1_dat : 32'h0);
      chk("m_ctl", {wb_we_o, wb_sel_o, wb_cti_o, wb_bte_o},
          (owner == 0) ? {m0_we, m0_sel, m0_cti, m0_bte} :
          (owner == 1) ? {m1_we, m1_sel, m1_cti, m1_bte} : 10'h0);
      chk("m_ack0", m0_ack_o, live && wb_ack && owner == 0);
      chk("m_ack1", m1_ack_o, live && wb_ack && owner == 1);
      chk("m_err0", m0_err_o, live && (wb_err || wd) && owner == 0);
      chk("m_err1", m1_err_o, live && (wb_err || wd) && owner == 1);
      chk("m_rdat", {m0_dat_o, m1_dat_o}, {wb_dat, wb_dat});
      chk("m_tmo", tmo_o, mtmo);
      if (wd) mtmo = 1'b1;
      else if (tmo_clr) mtmo = 1'b0;
      if (live && ostb && !rsp) stall = (stall < 255) ? stall + 1 : stall;
      else stall = 0;
      if (owner < 0) begin
        if (m0_cyc || m1_cyc) begin
          owner = (m0_cyc && m1_cyc) ? (1 - last) : (m0_cyc ? 0 : 1);
          last = owner;
        end
        stall = 0;
      end else if (!ocyc) begin
        owner = -1;
        dead = 1'b0;
      end else if (wd) begin
        dead = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output logic [1:0] g);
    g = 2'b00;
    for (int i = 0; i < 10; i++) begin
      if (gnt_o != 2'b00) begin
        g = gnt_o;
        break;
      end
      step();
    end
    if (g == 2'b00) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_gnt: gnt_o still 00 after 10 cycles");
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    wb_ack = 1'b0; wb_err = 1'b0; tmo_clr = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] g;
    logic [1:0] gseq [4];
    int b0, b1, first_stb, err_at;

    // Reset state
    step();
    @(negedge clk);
    chk("reset_gnt", gnt_o, 2'b00);
    chk("reset_tmo", tmo_o, 0);
    step();
    rst_n = 1'b1;
    step();

    // 1: port 0 read alone
    b0 = n_ack0; b1 = n_ack1;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 32'h1000_0040; m0_sel = 4'hF;
    step();
    @(negedge clk);
    chk("t1_gnt", gnt_o, 2'b01);
    step();
    step();
    wb_ack = 1'b1; wb_dat = 32'hA5A5_0001;
    @(negedge clk);
    chk("t1_m0_ack", m0_ack_o, 1);
    chk("t1_m0_dat", m0_dat_o, 32'hA5A5_0001);
    step();
    wb_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    step();
    step();
    chk("t1_ack0_pulses", n_ack0 - b0, 1);
    chk("t1_ack1_pulses", n_ack1 - b1, 0);

    // 2: simultaneous requests alternate starting with port 0
    do_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h1000_0100;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_adr = 32'h2000_0100; m1_dat = 32'h1234_5678;
    m1_sel = 4'h3;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(g);
      gseq[k] = g;
      wb_ack = 1'b1; wb_dat = 32'h0000_1000 + k;
      step();
      wb_ack = 1'b0;
      if (g == 2'b01 || k == 3) begin m0_cyc = 1'b0; m0_stb = 1'b0; end
      if (g == 2'b10 || k == 3) begin m1_cyc = 1'b0; m1_stb = 1'b0; end
      step();
      if (k != 3) begin
        m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
      end
    end
    chk("t2_gnt0", gseq[0], 2'b01);
    chk("t2_gnt1", gseq[1], 2'b10);
    chk("t2_gnt2", gseq[2], 2'b01);
    chk("t2_gnt3", gseq[3], 2'b10);

    // 3: port 1 burst keeps grant while port 0 waits
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_cti = 3'b010; m1_sel = 4'hF;
    m1_adr = 32'h2000_0000; m1_dat = 32'hD000_0000;
    step();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 32'h3000_0000;
    for (int bt = 0; bt < 4; bt++) begin
      wb_ack = 1'b1;
      if (bt == 3) m1_cti = 3'b111;
      @(negedge clk);
      chk("t3_gnt_hold", gnt_o, 2'b10);
      chk("t3_m1_ack", m1_ack_o, 1);
      chk("t3_m0_ack", m0_ack_o, 0);
      step();
      m1_adr = m1_adr + 32'd4; m1_dat = m1_dat + 32'd1;
    end
    wb_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0; m1_cti = 3'b000;
    @(negedge clk);
    chk("t3_cyc_drop", wb_cyc_o, 0);
    step();
    @(negedge clk);
    chk("t3_idle_gap", gnt_o, 2'b00);
    step();
    @(negedge clk);
    chk("t3_gnt_p0", gnt_o, 2'b01);
    step();
    wb_ack = 1'b1;
    step();
    wb_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    step();

    // 4: watchdog on a silent slave
    b0 = n_err0;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h4000_0000;
    first_stb = -1; err_at = -1;
    for (int c = 0; c < 40 && err_at < 0; c++) begin
      @(negedge clk);
      if (wb_stb_o && first_stb < 0) first_stb = c;
      if (m0_err_o) err_at = c;
      step();
    end
    chk("t4_first_stb", first_stb, 1);
    chk("t4_err_delay", err_at - first_stb, 16);
    @(negedge clk);
    chk("t4_tmo_set", tmo_o, 1);
    chk("t4_drain_cyc", wb_cyc_o, 0);
    chk("t4_drain_gnt", gnt_o, 2'b01);
    step();
    wb_ack = 1'b1;
    @(negedge clk);
    chk("t4_late_ack", m0_ack_o, 0);
    step();
    wb_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    step();
    @(negedge clk);
    chk("t4_tmo_sticky", tmo_o, 1);
    chk("t4_err_pulses", n_err0 - b0, 1);
    step();
    tmo_clr = 1'b1;
    step();
    tmo_clr = 1'b0;
    @(negedge clk);
    chk("t4_tmo_clr", tmo_o, 0);
    step();

    // 5: asynchronous reset in the middle of an access
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_adr = 32'h5000_0000;
    step();
    @(negedge clk);
    chk("t5_busy_cyc", wb_cyc_o, 1);
    chk("t5_busy_gnt", gnt_o, 2'b10);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_cyc", wb_cyc_o, 0);
    chk("t5_rst_stb", wb_stb_o, 0);
    chk("t5_rst_gnt", gnt_o, 2'b00);
    step();
    rst_n = 1'b1;
    m0_cyc = 1'b1; m0_stb = 1'b1;
    step();
    @(negedge clk);
    chk("t5_gnt_p0", gnt_o, 2'b01);

    // 6: slave error on a port 1 access
    step();
    wb_ack = 1'b1;
    step();
    wb_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    step();
    step();
    chk("t6_gnt_p1", gnt_o, 2'b10);
    wb_err = 1'b1;
    @(negedge clk);
    chk("t6_m1_err", m1_err_o, 1);
    chk("t6_m0_err", m0_err_o, 0);
    step();
    wb_err = 1'b0;
    @(negedge clk);
    chk("t6_tmo", tmo_o, 0);
    chk("t6_still_busy", {gnt_o, wb_cyc_o}, 3'b101);
    step();
    m1_cyc = 1'b0; m1_stb = 1'b0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
